// File: rtl/peripheral_dpram_stream.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_dpram_stream
// Purpose  : J1 I/O-bus peripheral. The CPU reads and writes a 128x16 word
//            RAM through port A. Port B plays a CPU-programmed RAM region
//            (BASE, LEN) out on a valid/ready stream.
// Revision : 1.0  initial release
// ============================================================================
module peripheral_dpram_stream #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] d_in,
    input  logic              cs,
    input  logic [7:0]        addr,
    input  logic              rd,
    input  logic              wr,
    output logic [DATA_W-1:0] d_out,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_last
);

    localparam int c_DEPTH = 1 << ADDR_W;

    localparam logic [7:0] c_ADDR_BASE   = 8'h80;
    localparam logic [7:0] c_ADDR_LEN    = 8'h81;
    localparam logic [7:0] c_ADDR_CTRL   = 8'h82;
    localparam logic [7:0] c_ADDR_STATUS = 8'h83;

    localparam logic [ADDR_W:0] c_LEN_MAX = (ADDR_W+1)'(c_DEPTH);
    localparam logic [ADDR_W:0] c_REM_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] c_REM_TWO = (ADDR_W+1)'(2);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_PRIME  = 2'd1;
    localparam logic [1:0] c_STREAM = 2'd2;

    logic [DATA_W-1:0] r_mem [0:c_DEPTH-1];

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_remaining;
    logic              r_busy;
    logic              r_done;
    logic              r_aborted;

    logic              w_wr;
    logic              w_rd;
    logic              w_ram_sel;
    logic              w_ctrl_wr;
    logic              w_go;
    logic              w_abort;
    logic              w_fire;
    logic [ADDR_W:0]   w_len_sat;
    logic [ADDR_W-1:0] w_ptr_next;
    logic [15:0]       w_status;
    logic [DATA_W-1:0] w_rd_val;

    assign w_wr       = cs & wr;
    assign w_rd       = cs & rd;
    assign w_ram_sel  = ~addr[7];
    assign w_ctrl_wr  = w_wr && (addr == c_ADDR_CTRL);
    assign w_go       = w_ctrl_wr & d_in[0];
    assign w_abort    = w_ctrl_wr & d_in[1];
    assign w_fire     = st_valid & st_ready;
    assign w_ptr_next = r_ptr + 1'b1;
    assign w_len_sat  = (d_in > DATA_W'(c_DEPTH)) ? c_LEN_MAX : d_in[ADDR_W:0];
    assign w_status   = {8'(r_remaining), 5'b0, r_aborted, r_done, r_busy};

    // CPU read mux; a RAM word is sampled before any same-edge write lands.
    always_comb begin
        w_rd_val = '0;
        if (w_ram_sel) begin
            w_rd_val = r_mem[addr[ADDR_W-1:0]];
        end else begin
            case (addr)
                c_ADDR_BASE:   w_rd_val = DATA_W'(r_base);
                c_ADDR_LEN:    w_rd_val = DATA_W'(r_len);
                c_ADDR_STATUS: w_rd_val = DATA_W'(w_status);
                default:       w_rd_val = '0;
            endcase
        end
    end

    // Port A write into the RAM array (contents survive reset).
    always_ff @(posedge clk) begin
        if (w_wr && w_ram_sel) begin
            r_mem[addr[ADDR_W-1:0]] <= d_in;
        end
    end

    // Registered CPU read data, held until the next read strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_out <= '0;
        end else if (w_rd) begin
            d_out <= w_rd_val;
        end
    end

    // Transfer descriptor; frozen while a transfer is in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base <= '0;
            r_len  <= '0;
        end else if (w_wr && !r_busy) begin
            if (addr == c_ADDR_BASE) r_base <= d_in[ADDR_W-1:0];
            if (addr == c_ADDR_LEN)  r_len  <= w_len_sat;
        end
    end

    // Stream engine: PRIME fetches the first word, STREAM prefetches ptr+1 on
    // every accepted beat so transfers run back-to-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_ptr       <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            st_data     <= '0;
            st_valid    <= 1'b0;
            st_last     <= 1'b0;
        end else if (w_abort) begin
            r_state     <= c_IDLE;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b1;
            st_valid    <= 1'b0;
            st_last     <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_go) begin
                        r_aborted <= 1'b0;
                        if (r_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_ptr       <= r_base;
                            r_remaining <= r_len;
                            r_busy      <= 1'b1;
                            r_done      <= 1'b0;
                            r_state     <= c_PRIME;
                        end
                    end
                end
                c_PRIME: begin
                    st_data  <= r_mem[r_ptr];
                    st_valid <= 1'b1;
                    st_last  <= (r_remaining == c_REM_ONE);
                    r_state  <= c_STREAM;
                end
                c_STREAM: begin
                    if (w_fire) begin
                        r_remaining <= r_remaining - 1'b1;
                        r_ptr       <= w_ptr_next;
                        if (r_remaining == c_REM_ONE) begin
                            st_valid <= 1'b0;
                            st_last  <= 1'b0;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= c_IDLE;
                        end else begin
                            st_data <= r_mem[w_ptr_next];
                            st_last <= (r_remaining == c_REM_TWO);
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_peripheral_dpram_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_peripheral_dpram_stream
// Purpose  : Self-checking bench for peripheral_dpram_stream. A flat memory
//            array and expected-word queues model the peripheral; stream
//            beats are captured by a monitor and compared against the model.
// Revision : 1.0  initial release
// ============================================================================
module tb_peripheral_dpram_stream;

    localparam logic [7:0] c_BASE   = 8'h80;
    localparam logic [7:0] c_LEN    = 8'h81;
    localparam logic [7:0] c_CTRL   = 8'h82;
    localparam logic [7:0] c_STATUS = 8'h83;

    logic        clk;
    logic        rst;
    logic [15:0] d_in;
    logic        cs;
    logic [7:0]  addr;
    logic        rd;
    logic        wr;
    logic [15:0] d_out;
    logic [15:0] st_data;
    logic        st_valid;
    logic        st_ready;
    logic        st_last;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] model_mem [128];
    logic [15:0] got_data [$];
    logic        got_last [$];
    logic [15:0] exp_data [$];

    logic        hold_v = 1'b0;
    logic [15:0] hold_d;
    logic        hold_l;

    peripheral_dpram_stream #(.DATA_W(16), .ADDR_W(7)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .d_in     (d_in),
        .cs       (cs),
        .addr     (addr),
        .rd       (rd),
        .wr       (wr),
        .d_out    (d_out),
        .st_data  (st_data),
        .st_valid (st_valid),
        .st_ready (st_ready),
        .st_last  (st_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // All stimulus changes 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [15:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
        step();
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] a, output logic [15:0] d);
        cs = 1'b1; rd = 1'b1; addr = a;
        step();
        d = d_out;
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic clear_capture();
        got_data.delete();
        got_last.delete();
        exp_data.delete();
    endtask

    // Expected words for a transfer: consecutive RAM words, wrapping at 128.
    task automatic build_expected(input int b, input int len);
        exp_data.delete();
        for (int i = 0; i < len; i++) exp_data.push_back(model_mem[(b + i) % 128]);
    endtask

    // Drives random backpressure until len beats arrive, then compares them.
    task automatic run_stream(input string tag, input int len, input int pct);
        int cyc;
        cyc = 0;
        while (got_data.size() < len && cyc < 40 * len + 40) begin
            st_ready = ($urandom_range(99) < pct);
            step();
            cyc++;
        end
        st_ready = 1'b1;
        step();
        check({tag, "_beats"}, got_data.size(), len);
        check({tag, "_idle_valid"}, {31'b0, st_valid}, 0);
        for (int i = 0; i < len && i < got_data.size(); i++) begin
            check({tag, "_data"}, got_data[i], exp_data[i]);
            check({tag, "_last"}, {31'b0, got_last[i]}, (i == len - 1) ? 1 : 0);
        end
    endtask

    // Beat capture and hold-stability monitor, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (hold_v && st_valid) begin
                check("hold_data", st_data, hold_d);
                check("hold_last", {31'b0, st_last}, {31'b0, hold_l});
            end
            if (st_valid && st_ready && !rst) begin
                got_data.push_back(st_data);
                got_last.push_back(st_last);
            end
            hold_v = st_valid && !st_ready && !rst;
            hold_d = st_data;
            hold_l = st_last;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] r;
        int b, len, pre, k;
        logic [15:0] v;
        int pat [4];
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;

        rst = 1'b1; st_ready = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0;
        addr = '0; d_in = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_dout", d_out, 0);
        check("rst_valid", {31'b0, st_valid}, 0);
        check("rst_last", {31'b0, st_last}, 0);
        check("rst_data", st_data, 0);
        cpu_read(c_STATUS, r);
        check("rst_status", r, 16'h0000);

        // Fill the whole RAM so the model knows every word.
        for (int i = 0; i < 128; i++) begin
            v = 16'($urandom);
            cpu_write(8'(i), v);
            model_mem[i] = v;
        end

        // Directed RAM access.
        cpu_write(8'h05, 16'h1234); model_mem[5] = 16'h1234;
        cpu_write(8'h7F, 16'hBEEF); model_mem[127] = 16'hBEEF;
        cpu_read(8'h05, r); check("ram_rd_05", r, 16'h1234);
        cpu_read(8'h7F, r); check("ram_rd_7f", r, 16'hBEEF);
        cpu_read(8'h90, r); check("rd_unmapped", r, 16'h0000);
        cpu_read(c_CTRL, r); check("rd_ctrl", r, 16'h0000);
        for (int i = 0; i < 6; i++) begin
            k = $urandom_range(0, 127);
            cpu_read(8'(k), r);
            check("ram_rd_rand", r, model_mem[k]);
        end

        // Simultaneous read and write returns the old word.
        cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 8'h05; d_in = 16'h5A5A;
        step();
        check("rdw_old", d_out, 16'h1234);
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
        model_mem[5] = 16'h5A5A;
        cpu_read(8'h05, r); check("rdw_new", r, 16'h5A5A);

        // Basic stream with st_ready held high.
        for (int i = 0; i < 4; i++) begin
            cpu_write(8'(10 + i), 16'(16'hA0 + i));
            model_mem[10 + i] = 16'(16'hA0 + i);
        end
        cpu_write(c_BASE, 16'd10);
        cpu_write(c_LEN, 16'd4);
        clear_capture();
        st_ready = 1'b1;
        cpu_write(c_CTRL, 16'h0001);
        check("basic_prime_valid", {31'b0, st_valid}, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            check("basic_valid", {31'b0, st_valid}, 1);
            check("basic_data", st_data, 32'(16'hA0 + i));
            check("basic_last", {31'b0, st_last}, (i == 3) ? 1 : 0);
            step();
        end
        check("basic_end_valid", {31'b0, st_valid}, 0);
        cpu_read(c_STATUS, r); check("basic_status", r, 16'h0002);

        // Backpressure and wrap from 126.
        model_mem[126] = 16'd1; model_mem[127] = 16'd2;
        model_mem[0] = 16'd3; model_mem[1] = 16'd4;
        cpu_write(8'd126, 16'd1); cpu_write(8'd127, 16'd2);
        cpu_write(8'd0, 16'd3); cpu_write(8'd1, 16'd4);
        cpu_write(c_BASE, 16'd126);
        cpu_write(c_LEN, 16'd4);
        clear_capture();
        build_expected(126, 4);
        st_ready = 1'b1;
        cpu_write(c_CTRL, 16'h0001);
        k = 0;
        while (got_data.size() < 4 && k < 100) begin
            pre = got_data.size();
            st_ready = pat[k % 4][0];
            cpu_read(c_STATUS, r);
            check("bp_remaining", {24'b0, r[15:8]}, 32'(4 - pre));
            k++;
        end
        st_ready = 1'b1;
        cpu_read(c_STATUS, r);
        check("bp_final_rem", {24'b0, r[15:8]}, 0);
        check("bp_final_flags", {24'b0, r[7:0]}, 32'h02);
        check("bp_beats", got_data.size(), 4);
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            check("bp_data", got_data[i], exp_data[i]);
            check("bp_last", {31'b0, got_last[i]}, (i == 3) ? 1 : 0);
        end

        // LEN=0 then GO: no beats, done set.
        cpu_write(c_LEN, 16'd0);
        clear_capture();
        cpu_write(c_CTRL, 16'h0001);
        for (int i = 0; i < 3; i++) begin
            check("len0_valid", {31'b0, st_valid}, 0);
            step();
        end
        cpu_read(c_STATUS, r); check("len0_status", r, 16'h0002);

        // LEN saturation.
        cpu_write(c_LEN, 16'd200);
        cpu_read(c_LEN, r); check("len_sat200", r, 16'd128);
        cpu_write(c_LEN, 16'd129);
        cpu_read(c_LEN, r); check("len_sat129", r, 16'd128);
        cpu_write(c_LEN, 16'd128);
        cpu_read(c_LEN, r); check("len_128", r, 16'd128);
        cpu_write(c_BASE, 16'hFFFF);
        cpu_read(c_BASE, r); check("base_mask", r, 16'h007F);

        // Busy write protection, GO while busy, then ABORT (with GO).
        cpu_write(c_BASE, 16'd20);
        cpu_write(c_LEN, 16'd8);
        clear_capture();
        st_ready = 1'b0;
        cpu_write(c_CTRL, 16'h0001);
        step();
        check("ab_first_valid", {31'b0, st_valid}, 1);
        check("ab_first_data", st_data, model_mem[20]);
        cpu_write(c_BASE, 16'd33);
        cpu_read(c_BASE, r); check("busy_base", r, 16'd20);
        cpu_write(c_LEN, 16'd3);
        cpu_read(c_LEN, r); check("busy_len", r, 16'd8);
        cpu_write(c_CTRL, 16'h0001);
        check("busy_go_data", st_data, model_mem[20]);
        cpu_read(c_STATUS, r); check("busy_status_flags", {24'b0, r[7:0]}, 32'h01);
        cpu_write(c_CTRL, 16'h0003);
        check("abort_valid", {31'b0, st_valid}, 0);
        cpu_read(c_STATUS, r); check("abort_status", {24'b0, r[7:0]}, 32'h04);
        step();
        check("abort_stays_idle", {31'b0, st_valid}, 0);
        check("abort_no_beats", got_data.size(), 0);

        // Randomized transfers against the model.
        for (int t = 0; t < 6; t++) begin
            b   = $urandom_range(0, 127);
            len = (t == 0) ? 128 : $urandom_range(1, 40);
            cpu_write(c_BASE, 16'(b));
            cpu_write(c_LEN, 16'(len));
            clear_capture();
            build_expected(b, len);
            st_ready = 1'b0;
            cpu_write(c_CTRL, 16'h0001);
            run_stream("rand", len, $urandom_range(30, 100));
            cpu_read(c_STATUS, r); check("rand_status", r, 16'h0002);
        end

        // Reset in the middle of a transfer.
        cpu_write(c_BASE, 16'd50);
        cpu_write(c_LEN, 16'd8);
        st_ready = 1'b0;
        cpu_write(c_CTRL, 16'h0001);
        step();
        check("rstmid_valid_before", {31'b0, st_valid}, 1);
        cpu_read(c_BASE, r); check("rstmid_base_before", r, 16'd50);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstmid_dout", d_out, 0);
        check("rstmid_valid", {31'b0, st_valid}, 0);
        check("rstmid_last", {31'b0, st_last}, 0);
        check("rstmid_data", st_data, 0);
        cpu_read(c_STATUS, r); check("rstmid_status", r, 16'h0000);
        cpu_read(c_BASE, r); check("rstmid_base", r, 16'h0000);
        cpu_read(c_LEN, r); check("rstmid_len", r, 16'h0000);
        cpu_read(8'd50, r); check("rstmid_ram_kept", r, model_mem[50]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
